time_keeper_set: RTL and testbench

- Time-of-day counter that consumes the divided 1 Hz square wave, either the normal 1 Hz rate or the fast set-time rate, from the upstream frequency divider.
- Keeps HH:MM:SS and adds a button-driven set-time mode.
- The divided wave is treated as data, never as a clock: it is synchronised into the system clock domain and edge-detected into a one-cycle tick.
- Outputs feed the display/decoder stage.

---
 rtl/time_keeper_set.sv | 96 +++++++++
 tb/tb_time_keeper_set.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/time_keeper_set.sv
// time_keeper_set: HH:MM:SS time-of-day counter with button-driven set mode.
// Define HOUR12_EN for a 12-hour display with pm flag.
`timescale 1ns/1ps
module time_keeper_set #(
  parameter int SYNC_STAGES = 2,
  parameter int INIT_HH = 0,
  parameter int INIT_MM = 0,
  parameter int INIT_SS = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       set_btn,
  input  logic       sel_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] field_sel,
  output logic       blink,
  output logic       day_pulse,
  output logic       pm
);
  localparam logic [4:0] H0 = (INIT_HH >= 0 && INIT_HH <= 23) ? 5'(INIT_HH) : 5'd0;
  localparam logic [5:0] M0 = (INIT_MM >= 0 && INIT_MM <= 59) ? 6'(INIT_MM) : 6'd0;
  localparam logic [5:0] S0 = (INIT_SS >= 0 && INIT_SS <= 59) ? 6'(INIT_SS) : 6'd0;
  typedef enum logic [1:0] {RUN, SET_HH, SET_MM, SET_SS} state_t;
  state_t state, nxt;
  logic [4:0] sy [SYNC_STAGES];
  logic [4:0] dly;
  logic [4:0] hh;
  logic tick, set_p, sel_p, inc_p, dec_p;
  logic run_tick, adj, s_w, m_w, h_w, blink_q;
  function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] top, input logic up);
    return up ? ((v == top) ? 6'd0 : v + 6'd1) : ((v == 6'd0) ? top : v - 6'd1);
  endfunction
  // Buttons and the divided wave are data: synchronise, then edge-detect.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sy[i] <= '0;
      dly <= '0;
    end else begin
      sy[0] <= {dec_btn, inc_btn, sel_btn, set_btn, tick_in};
      for (int i = 1; i < SYNC_STAGES; i++) sy[i] <= sy[i-1];
      dly <= sy[SYNC_STAGES-1];
    end
  assign {dec_p, inc_p, sel_p, set_p, tick} = sy[SYNC_STAGES-1] & ~dly;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= nxt;
  always_comb begin
    nxt = set_p ? ((state == RUN) ? SET_HH : RUN) :
          (sel_p && state != RUN) ? ((state == SET_SS) ? SET_HH : state_t'(state + 2'd1)) :
          state;
  end
  always_comb begin
    field_sel = state;
    blink = blink_q && state != RUN;
`ifdef HOUR12_EN
    hours = (hh == 5'd0) ? 5'd12 : (hh > 5'd12) ? hh - 5'd12 : hh;
    pm = hh >= 5'd12;
`else
    hours = hh;
    pm = 1'b0;
`endif
  end
  assign s_w = seconds == 6'd59;
  assign m_w = minutes == 6'd59;
  assign h_w = hh == 5'd23;
  assign run_tick = state == RUN && tick;
  // Simultaneous inc and dec cancel out.
  assign adj = state != RUN && (inc_p ^ dec_p);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hh <= H0;
      minutes <= M0;
      seconds <= S0;
      day_pulse <= 1'b0;
    end else begin
      day_pulse <= run_tick && s_w && m_w && h_w;
      if (run_tick) begin
        seconds <= step(seconds, 6'd59, 1'b1);
        if (s_w) minutes <= step(minutes, 6'd59, 1'b1);
        if (s_w && m_w) hh <= 5'(step({1'b0, hh}, 6'd23, 1'b1));
      end else if (adj) begin
        if (state == SET_HH) hh <= 5'(step({1'b0, hh}, 6'd23, inc_p));
        if (state == SET_MM) minutes <= step(minutes, 6'd59, inc_p);
        if (state == SET_SS) seconds <= step(seconds, 6'd59, inc_p);
      end
    end
  // Blink restarts low whenever a field becomes selected.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) blink_q <= 1'b0;
    else blink_q <= (nxt == RUN || nxt != state) ? 1'b0 : blink_q ^ tick;
endmodule

// File: tb/tb_time_keeper_set.sv
// tb_time_keeper_set: directed vectors for time_keeper_set (INIT 23:59:58).
`timescale 1ns/1ps
module tb_time_keeper_set;
  logic clk, rst_n;
  logic [4:0] btn;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic [1:0] field_sel;
  logic blink, day_pulse, pm;
  int nvec, nerr, dp_cnt;
  localparam logic [4:0] TK = 5'd1, ST = 5'd2, SL = 5'd4, IN = 5'd8, DN = 5'd16;
  time_keeper_set #(.SYNC_STAGES(2), .INIT_HH(23), .INIT_MM(59), .INIT_SS(58)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(btn[0]), .set_btn(btn[1]), .sel_btn(btn[2]),
    .inc_btn(btn[3]), .dec_btn(btn[4]), .hours(hours), .minutes(minutes),
    .seconds(seconds), .field_sel(field_sel), .blink(blink), .day_pulse(day_pulse), .pm(pm)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (day_pulse) dp_cnt++;
  function automatic int exp_h(input int h);
`ifdef HOUR12_EN
    return (h == 0) ? 12 : (h > 12) ? h - 12 : h;
`else
    return h;
`endif
  endfunction
  function automatic int exp_pm(input int h);
`ifdef HOUR12_EN
    return h >= 12 ? 1 : 0;
`else
    return 0;
`endif
  endfunction
  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_t(input string tag, input int h, input int m, input int s);
    chk({tag, ".hh"}, hours, exp_h(h));
    chk({tag, ".pm"}, pm, exp_pm(h));
    chk({tag, ".mm"}, minutes, m);
    chk({tag, ".ss"}, seconds, s);
  endtask
  task automatic press(input logic [4:0] m, input int n);
    repeat (n) begin
      @(negedge clk) btn = btn | m;
      repeat (2) @(negedge clk);
      btn = btn & ~m;
      repeat (3) @(negedge clk);
    end
  endtask
  initial begin
    nvec = 0; nerr = 0; dp_cnt = 0;
    rst_n = 1'b0; btn = '0;
    repeat (2) @(negedge clk);
    chk_t("reset", 23, 59, 58);
    chk("reset.fs", field_sel, 0);
    chk("reset.blink", blink, 0);
    chk("reset.dp", day_pulse, 0);
    rst_n = 1'b1;
    @(negedge clk) btn[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("lat1.early", seconds, 58);
    @(negedge clk);
    chk("lat1.ss", seconds, 59);
    btn[0] = 1'b0;
    repeat (4) @(negedge clk);
    btn[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("lat2.early", seconds, 59);
    chk("lat2.dp_early", day_pulse, 0);
    @(negedge clk);
    chk_t("roll", 0, 0, 0);
    chk("roll.dp", day_pulse, 1);
    @(negedge clk);
    chk("roll.dp_end", day_pulse, 0);
    chk("roll.dp_cnt", dp_cnt, 1);
    btn[0] = 1'b0;
    repeat (4) @(negedge clk);
    press(ST, 1);
    chk("set.fs", field_sel, 1);
    chk("set.blink", blink, 0);
    press(IN, 10); press(SL, 1); press(IN, 20); press(SL, 1); press(IN, 30); press(ST, 1);
    chk_t("load", 10, 20, 30);
    chk("load.fs", field_sel, 0);
    press(ST, 1);
    chk("p2.fs_hh", field_sel, 1);
    press(SL, 1);
    chk("p2.fs_mm", field_sel, 2);
    press(IN, 3);
    press(TK, 1);
    chk("p2.blink_on", blink, 1);
    press(TK, 1);
    chk("p2.blink_off", blink, 0);
    chk_t("p2", 10, 23, 30);
    press(ST, 1);
    chk("p2.fs_run", field_sel, 0);
    press(ST, 1); press(SL, 2);
    chk("p3.fs_ss", field_sel, 3);
    chk("p3.ss_kept", seconds, 30);
    press(IN, 30);
    chk_t("p3.inc_wrap", 10, 23, 0);
    press(DN, 1);
    chk_t("p3.dec_wrap", 10, 23, 59);
    press(SL, 1);
    chk("p3.fs_hh", field_sel, 1);
    press(IN, 13);
    chk("p3.h23", hours, exp_h(23));
    press(IN, 1);
    chk_t("p3.h_wrap", 0, 23, 59);
    chk("p3.no_dp", dp_cnt, 1);
    press(DN, 1);
    chk("p3.h_dec_wrap", hours, exp_h(23));
    press(IN, 1);
    press(SL, 1);
    press(IN | DN, 1);
    chk("p4.incdec", minutes, 23);
    press(ST, 1);
    press(SL, 1);
    chk("p4.sel_run", field_sel, 0);
    press(ST, 1);
    press(IN, 12);
    chk_t("h12", 12, 23, 59);
    press(IN, 1);
    chk_t("h13", 13, 23, 59);
    press(IN, 16); press(SL, 1); press(IN, 37); press(SL, 1); press(IN, 11); press(ST, 1);
    chk_t("p5.load", 5, 0, 10);
    press(TK | ST, 1);
    chk("p5.tick_run", seconds, 11);
    chk("p5.fs", field_sel, 1);
    press(TK | ST, 1);
    chk("p5.tick_drop", seconds, 11);
    chk("p5.fs_run", field_sel, 0);
    press(ST, 1); press(SL, 1); press(TK, 1);
    chk("p5.blink_mm", blink, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_t("arst", 23, 59, 58);
    chk("arst.fs", field_sel, 0);
    chk("arst.blink", blink, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
